// File: rtl/lcd_pix_fifo.sv
// Elastic pixel buffer between a valid/ready pixel producer and lcd_ctrl's data_req interface.
// Aligns producer frames (tagged by sof) to display frame starts and recovers from slips.
module lcd_pix_fifo #(
  parameter int unsigned        DATA_W      = 24,
  parameter int unsigned        DEPTH       = 512,
  parameter logic [DATA_W-1:0]  UFLOW_COLOR = '0
) (
  input  logic                       clk_in,
  input  logic                       sys_rst,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_sof,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       data_req,
  input  logic [9:0]                 pix_x,
  input  logic [9:0]                 pix_y,
  output logic [DATA_W-1:0]          pix_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       locked,
  output logic [15:0]                err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StSyncWait, StArmed, StStream} state_e;

  state_e                state_q, state_d;
  logic [DATA_W:0]       mem [DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [AW:0]           level_q, level_d;
  logic                  s_ready_q, s_ready_d;
  logic [DATA_W-1:0]     pix_q;
  logic [15:0]           err_q;

  logic                  push, frame_start, empty, head_sof;
  logic [DATA_W:0]       head;
  logic                  wr, pop, flush, uflow, err_inc;

  assign push        = s_valid && s_ready_q;
  assign frame_start = data_req && (pix_x == 10'd0) && (pix_y == 10'd0);
  assign empty       = (level_q == '0);
  assign head        = mem[rptr_q];
  assign head_sof    = head[DATA_W];

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      state_q   <= StSyncWait;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b0;
      pix_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      s_ready_q <= s_ready_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        wptr_q <= wptr_q + AW'(wr);
        rptr_q <= rptr_q + AW'(pop);
      end
      if (data_req) begin
        pix_q <= uflow ? UFLOW_COLOR : head[DATA_W-1:0];
      end
      if (err_inc && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!sys_rst && wr) begin
      mem[wptr_q] <= {s_sof, s_data};
    end
  end

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    uflow   = 1'b0;
    err_inc = 1'b0;
    unique case (state_q)
      StSyncWait: begin
        // Non-SOF beats are accepted but never stored, keeping the FIFO empty.
        uflow = 1'b1;
        if (push && s_sof) begin
          wr      = 1'b1;
          state_d = StArmed;
        end
      end
      StArmed: begin
        wr = push;
        if (frame_start) begin
          pop     = 1'b1;
          state_d = StStream;
        end else begin
          uflow = 1'b1;
        end
      end
      StStream: begin
        if (data_req) begin
          if (empty) begin
            uflow   = 1'b1;
            err_inc = 1'b1;
            flush   = 1'b1;
          end else if (head_sof && !frame_start) begin
            uflow   = 1'b1;
            err_inc = 1'b1;
            state_d = StArmed;
          end else if (!head_sof && frame_start) begin
            uflow   = 1'b1;
            err_inc = 1'b1;
            flush   = 1'b1;
          end else begin
            pop = 1'b1;
          end
        end
        wr = push && !flush;
        if (flush) begin
          state_d = StSyncWait;
        end
      end
      default: begin
        state_d = StSyncWait;
        flush   = 1'b1;
      end
    endcase
  end

  always_comb begin
    level_d   = flush ? '0 : level_q + (AW+1)'(wr) - (AW+1)'(pop);
    // Registered from the next level so a full FIFO never takes a beat, even alongside a pop.
    s_ready_d = (state_d == StSyncWait) || (level_d != (AW+1)'(DEPTH));
  end

  always_comb begin
    locked     = (state_q == StStream);
    s_ready    = s_ready_q;
    pix_data   = pix_q;
    fifo_level = level_q;
    err_cnt    = err_q;
  end

endmodule

// File: tb/tb_lcd_pix_fifo.sv
// Bench for lcd_pix_fifo: directed vector table, hand sequences and randomized traffic,
// all checked every cycle against a queue-based model of the buffering rules.
module tb_lcd_pix_fifo;

  localparam int DEPTH = 512;
  localparam int W     = 16;
  localparam int H     = 4;
  localparam logic [23:0] UF = 24'h000000;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [23:0] s_data;
  logic        s_sof, s_valid, s_ready;
  logic        data_req;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_data;
  logic [9:0]  fifo_level;
  logic        locked;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  lcd_pix_fifo #(.DATA_W(24), .DEPTH(DEPTH), .UFLOW_COLOR(UF)) dut (
    .clk_in    (clk),
    .sys_rst   (sys_rst),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .data_req  (data_req),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_data  (pix_data),
    .fifo_level(fifo_level),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = waiting for sof, 1 = armed, 2 = streaming.
  int          m_mode;
  logic [24:0] m_q[$];
  int          m_err;
  logic [23:0] m_pd;
  bit          m_rdy;
  bit          m_acc;
  bit          chk_en;
  logic [24:0] src[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit          push, fs, flush;
    int          nm;
    logic [24:0] hd;
    if (sys_rst) begin
      m_mode = 0; m_q.delete(); m_err = 0; m_pd = '0; m_rdy = 0; m_acc = 0;
    end else begin
      push  = s_valid && m_rdy;
      m_acc = push;
      fs    = data_req && pix_x == 0 && pix_y == 0;
      flush = 0;
      nm    = m_mode;
      if (m_mode == 0) begin
        if (data_req) m_pd = UF;
        if (push && s_sof) begin
          m_q.push_back({s_sof, s_data});
          nm = 1;
        end
      end else if (m_mode == 1) begin
        if (data_req) begin
          if (fs) begin
            hd = m_q.pop_front(); m_pd = hd[23:0]; nm = 2;
          end else m_pd = UF;
        end
        if (push) m_q.push_back({s_sof, s_data});
      end else begin
        if (data_req) begin
          if (m_q.size() == 0) begin
            m_pd = UF; m_err++; flush = 1;
          end else if (m_q[0][24] != fs) begin
            m_pd = UF; m_err++;
            if (fs) flush = 1;
            else nm = 1;
          end else begin
            hd = m_q.pop_front(); m_pd = hd[23:0];
          end
        end
        if (flush) begin
          m_q.delete(); nm = 0;
        end else if (push) m_q.push_back({s_sof, s_data});
      end
      if (m_err > 65535) m_err = 65535;
      m_mode = nm;
      m_rdy  = (nm == 0) || (m_q.size() != DEPTH);
    end
  endtask

  // Compare outputs (state after the previous edge), advance the model, clock once.
  task automatic step();
    if (chk_en) begin
      check("pix_data", 32'(pix_data), 32'(m_pd));
      check("s_ready", 32'(s_ready), 32'(m_rdy));
      check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      check("locked", 32'(locked), 32'(m_mode == 2));
      check("err_cnt", 32'(err_cnt), 32'(m_err));
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit rq, input int x, input int y, input int pv);
    if (src.size() > 0 && $urandom_range(99) < pv) begin
      s_valid = 1'b1;
      {s_sof, s_data} = src[0];
    end else begin
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_data  = 24'($urandom);
    end
    data_req = rq;
    pix_x    = rq ? 10'(x) : 10'($urandom);
    pix_y    = rq ? 10'(y) : 10'($urandom);
    step();
    if (m_acc) void'(src.pop_front());
  endtask

  task automatic frame_reqs(input int npix, input int preq, input int pv);
    for (int k = 0; k < npix; k++) begin
      while ($urandom_range(99) >= preq) cycle(1'b0, 0, 0, pv);
      cycle(1'b1, k % W, k / W, pv);
    end
  endtask

  task automatic gen_frame(input int len, input int base);
    for (int k = 0; k < len; k++) src.push_back({k == 0, 24'(base + (k / W) * 800 + k % W)});
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; s_valid = 0; s_sof = 0; s_data = 0; data_req = 0; pix_x = 0; pix_y = 0;
    src.delete();
    step();
    sys_rst = 1'b0;
  endtask

  typedef struct {
    bit          v;
    bit          sof;
    logic [23:0] d;
    bit          rq;
    int          x;
    int          y;
    int          lvl;
    bit          lk;
    logic [23:0] px;
    int          er;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 0, 24'h000001, 0, 0, 0, 0, 0, 24'h0,      0};
    tbl[1] = '{1, 0, 24'h000002, 0, 0, 0, 0, 0, 24'h0,      0};
    tbl[2] = '{1, 0, 24'h000003, 0, 0, 0, 0, 0, 24'h0,      0};
    tbl[3] = '{1, 1, 24'hABCDEF, 0, 0, 0, 1, 0, 24'h0,      0};
    tbl[4] = '{0, 0, 24'h0,      1, 5, 0, 1, 0, 24'h0,      0};
    tbl[5] = '{0, 0, 24'h0,      1, 0, 0, 0, 1, 24'hABCDEF, 0};
    tbl[6] = '{0, 0, 24'h0,      1, 1, 0, 0, 0, 24'h0,      1};
    tbl[7] = '{1, 1, 24'h123456, 0, 0, 0, 1, 0, 24'h0,      1};
    tbl[8] = '{0, 0, 24'h0,      1, 0, 0, 0, 1, 24'h123456, 1};

    // Reset and first post-reset cycle.
    chk_en  = 0;
    sys_rst = 1'b1; s_valid = 0; s_sof = 0; s_data = 0; data_req = 0; pix_x = 0; pix_y = 0;
    step();
    chk_en = 1;
    step();
    check("rst s_ready", 32'(s_ready), 0);
    check("rst level", 32'(fifo_level), 0);
    sys_rst = 1'b0;
    step();
    check("ready after rst", 32'(s_ready), 1);

    // Directed table: discard of non-sof beats, arming, underflow and re-arm.
    for (int i = 0; i < 9; i++) begin
      s_valid = tbl[i].v; s_sof = tbl[i].sof; s_data = tbl[i].d;
      data_req = tbl[i].rq; pix_x = 10'(tbl[i].x); pix_y = 10'(tbl[i].y);
      step();
      check($sformatf("tbl%0d level", i), 32'(fifo_level), 32'(tbl[i].lvl));
      check($sformatf("tbl%0d locked", i), 32'(locked), 32'(tbl[i].lk));
      check($sformatf("tbl%0d pix", i), 32'(pix_data), 32'(tbl[i].px));
      check($sformatf("tbl%0d err", i), 32'(err_cnt), 32'(tbl[i].er));
    end

    // Two aligned frames with producer running alongside the display.
    do_reset();
    gen_frame(W * H, 0);
    gen_frame(W * H, 0);
    for (int i = 0; i < 1000 && src.size() > W * H; i++) cycle(1'b0, 0, 0, 75);
    frame_reqs(W * H, 33, 75);
    frame_reqs(W * H, 33, 75);
    cycle(1'b0, 0, 0, 0);
    check("frames err", 32'(err_cnt), 0);
    check("frames locked", 32'(locked), 1);

    // Producer frame one pixel short.
    do_reset();
    gen_frame(W * H - 1, 0);
    gen_frame(W * H, 1000);
    for (int i = 0; i < 300 && src.size() > 0; i++) cycle(1'b0, 0, 0, 100);
    frame_reqs(W * H, 50, 0);
    cycle(1'b0, 0, 0, 0);
    check("short err", 32'(err_cnt), 1);
    check("short locked", 32'(locked), 0);
    check("short level", 32'(fifo_level), W * H);
    cycle(1'b1, 0, 0, 0);
    check("relock pix", 32'(pix_data), 1000);
    check("relock locked", 32'(locked), 1);
    frame_reqs(W * H - 1, 50, 0);

    // Fill to DEPTH, then pop with a concurrent beat held off by s_ready.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) src.push_back({i == 0, 24'(i)});
    for (int i = 0; i < DEPTH + 8; i++) cycle(1'b0, 0, 0, 100);
    check("full level", 32'(fifo_level), DEPTH);
    check("full ready", 32'(s_ready), 0);
    cycle(1'b1, 0, 0, 100);
    check("pop at full level", 32'(fifo_level), DEPTH - 1);
    check("pop at full ready", 32'(s_ready), 1);
    cycle(1'b0, 0, 0, 100);
    check("refill level", 32'(fifo_level), DEPTH);
    for (int k = 1; k <= DEPTH; k++) cycle(1'b1, k, 0, 0);
    cycle(1'b0, 0, 0, 0);
    check("drain level", 32'(fifo_level), 0);
    check("drain last", 32'(pix_data), DEPTH);

    // Random frame lengths and gaps: misalignment in both directions.
    do_reset();
    for (int f = 0; f < 8; f++) gen_frame(W * H - 3 + int'($urandom_range(6)), f * 2000);
    begin
      int k = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(99) < 40) begin
          cycle(1'b1, k % W, k / W, 60);
          k = (k + 1) % (W * H);
        end else cycle(1'b0, 0, 0, 60);
      end
    end

    // Reset mid-frame.
    do_reset();
    gen_frame(W * H, 0);
    for (int i = 0; i < 200 && src.size() > 0; i++) cycle(1'b0, 0, 0, 100);
    frame_reqs(20, 100, 0);
    gen_frame(4, 0);
    sys_rst = 1'b1;
    cycle(1'b1, 20 % W, 20 / W, 100);
    sys_rst = 1'b0;
    check("midrst pix", 32'(pix_data), 0);
    check("midrst level", 32'(fifo_level), 0);
    check("midrst err", 32'(err_cnt), 0);
    check("midrst locked", 32'(locked), 0);
    check("midrst ready", 32'(s_ready), 0);
    src.delete();
    cycle(1'b1, 0, 0, 0);
    check("post rst ready", 32'(s_ready), 1);
    check("post rst uflow", 32'(pix_data), 32'(UF));
    cycle(1'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
